// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS core: opcodes, funct
// codes, FSM states and the instruction classes produced by decode.
package mips_pkg;

  localparam int ADDR_W_DEF = 18;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH_HI, FETCH_LO, DECODE, EXEC, MEM_HI, MEM_LO, WB
  } state_e;

  typedef enum logic [2:0] {
    I_NOP, I_ALU_R, I_ADDI, I_LW, I_SW, I_BEQ, I_J
  } instr_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port; register 0 always reads zero and is never written.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  output logic [31:0] rd1_o,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] registers [32];

  // NOTE: this array is reset explicitly because software relies on every
  // register starting at zero; that makes it flops, not a RAM macro.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : registers[ra2_i];

endmodule

// File: rtl/mips.sv
// Multi-cycle, non-pipelined MIPS subset core sequencing 32-bit accesses as
// two big-endian halfword cycles on an asynchronous 16-bit SRAM.
module mips
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clockFast,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  output logic              wre,
  output logic              oute,
  output logic              hb_mask,
  output logic              lb_mask,
  output logic              chip_en
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, mdr_q, mdr_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rd1, rd2, alu_res, pc_plus4;
  logic [31:0] bus_byte;
  logic [15:0] wdata;
  logic        bus_active, bus_write;
  instr_e      kind;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    kind = I_NOP;
    case (op)
      OP_RTYPE: if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) kind = I_ALU_R;
      OP_ADDI:  kind = I_ADDI;
      OP_LW:    kind = I_LW;
      OP_SW:    kind = I_SW;
      OP_BEQ:   kind = I_BEQ;
      OP_J:     kind = I_J;
      default:  kind = I_NOP;
    endcase
  end

  always_comb begin
    alu_res = rd1 + imm_sext;
    if (kind == I_ALU_R) begin
      case (funct)
        FN_SUB:  alu_res = rd1 - rd2;
        FN_AND:  alu_res = rd1 & rd2;
        FN_OR:   alu_res = rd1 | rd2;
        FN_SLT:  alu_res = {31'b0, $signed(rd1) < $signed(rd2)};
        default: alu_res = rd1 + rd2;
      endcase
    end
  end

  mips_regfile REGISTERS (
    .clk_i (clockFast),
    .rst_i (reset),
    .ra1_i (rs),
    .rd1_o (rd1),
    .ra2_i (rt),
    .rd2_o (rd2),
    .we_i  ((state_q == WB) && !reset),
    .wa_i  ((kind == I_ALU_R) ? rd : rt),
    .wd_i  ((kind == I_LW) ? mdr_q : alu_q)
  );

  // Reset gates the strobes combinationally so an aborted store never lands.
  always_comb begin
    bus_byte = pc_q;
    case (state_q)
      FETCH_LO: bus_byte = pc_q + 32'd2;
      MEM_HI:   bus_byte = alu_q;
      MEM_LO:   bus_byte = alu_q + 32'd2;
      default:  bus_byte = pc_q;
    endcase
  end

  assign bus_active = !reset && (state_q inside {FETCH_HI, FETCH_LO, MEM_HI, MEM_LO});
  assign bus_write  = bus_active && (state_q inside {MEM_HI, MEM_LO}) && (kind == I_SW);
  assign wdata      = (state_q == MEM_HI) ? rd2[31:16] : rd2[15:0];

  assign addr    = bus_byte[ADDR_W:1];
  assign chip_en = !bus_active;
  assign oute    = !(bus_active && !bus_write);
  assign wre     = !bus_write;
  assign hb_mask = 1'b0;
  assign lb_mask = 1'b0;
  assign data    = !wre ? wdata : 16'hzzzz;

  logic unused_bits;
  assign unused_bits = ^{bus_byte, ir_q[10:6]};

  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    case (state_q)
      FETCH_HI: begin
        ir_d[31:16] = data;
        state_d     = FETCH_LO;
      end
      FETCH_LO: begin
        ir_d[15:0] = data;
        state_d    = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        alu_d = alu_res;
        pc_d  = pc_plus4;
        if (kind == I_BEQ && rd1 == rd2) pc_d = pc_plus4 + (imm_sext << 2);
        if (kind == I_J) pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        case (kind)
          I_LW, I_SW:      state_d = MEM_HI;
          I_ALU_R, I_ADDI: state_d = WB;
          default:         state_d = FETCH_HI;
        endcase
      end
      MEM_HI: begin
        if (kind == I_LW) mdr_d[31:16] = data;
        state_d = MEM_LO;
      end
      MEM_LO: begin
        if (kind == I_LW) mdr_d[15:0] = data;
        state_d = (kind == I_LW) ? WB : FETCH_HI;
      end
      default: state_d = FETCH_HI;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clockFast) begin
    if (reset) begin
      state_q <= FETCH_HI;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

endmodule

// File: tb/tb_mips.sv
// Scoreboard bench for mips: stimulus queues expected SRAM bus cycles, a
// negedge monitor pops and compares each active bus cycle.
module tb_mips;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [15:0] data;
  logic [17:0] addr;
  logic        wre, oute, hb, lb, ce;

  always #5 clk = ~clk;

  mips #(.ADDR_W(18), .RESET_PC(32'h0)) dut (
    .clockFast (clk),
    .reset     (reset),
    .addr      (addr),
    .data      (data),
    .wre       (wre),
    .oute      (oute),
    .hb_mask   (hb),
    .lb_mask   (lb),
    .chip_en   (ce)
  );

  logic [15:0] mem [1024];
  int          wr_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign data = (!ce && !oute && wre) ? mem[addr[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce && !wre) begin
      mem[addr[9:0]] = data;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    logic [17:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } bus_t;

  bus_t exp_q[$];
  bus_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!ce && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("bus_addr", 32'(addr), 32'(mon_e.addr));
      check("bus_wre", 32'(wre), 32'(!mon_e.wr));
      check("bus_oute", 32'(oute), 32'(mon_e.wr));
      check("bus_masks", {30'b0, hb, lb}, 32'h0);
      if (mon_e.wr) check("bus_wdata", 32'(data), 32'(mon_e.wdata));
    end
  end

  task automatic exp_rd(input int ha);
    exp_q.push_back('{addr: ha[17:0], wr: 1'b0, wdata: 16'h0});
  endtask

  task automatic exp_wr(input int ha, input logic [15:0] d);
    exp_q.push_back('{addr: ha[17:0], wr: 1'b1, wdata: d});
  endtask

  task automatic exp_fetches(input int first_byte, input int n_instr);
    for (int i = 0; i < n_instr; i++) begin
      exp_rd((first_byte / 2) + 2 * i);
      exp_rd((first_byte / 2) + 2 * i + 1);
    end
  endtask

  task automatic put(input int byte_a, input logic [31:0] w);
    mem[byte_a / 2]     = w[31:16];
    mem[byte_a / 2 + 1] = w[15:0];
  endtask

  task automatic new_test();
    exp_q.delete();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    wr_count = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus_idle", {29'b0, ce, oute, wre}, 32'h7);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // addi $2,$0,5: result lands at the end of the fifth cycle
    new_test();
    put(0, 32'h2002_0005);
    exp_fetches(0, 2);
    do_reset();
    run(4);
    check("addi_before_wb", dut.REGISTERS.registers[2], 32'h0);
    run(6);
    check("addi_r2", dut.REGISTERS.registers[2], 32'd5);
    check("t1_queue_drained", exp_q.size(), 0);

    // ALU ops with a negative operand
    new_test();
    put(0,  32'h2001_0007);
    put(4,  32'h2002_FFFD);
    put(8,  32'h0022_1820);
    put(12, 32'h0041_202A);
    put(16, 32'h0022_2822);
    put(20, 32'h0022_3024);
    put(24, 32'h0022_3825);
    put(28, 32'h0022_402A);
    exp_fetches(0, 8);
    do_reset();
    check("reset_clears_r2", dut.REGISTERS.registers[2], 32'h0);
    run(40);
    check("add_r3", dut.REGISTERS.registers[3], 32'd4);
    check("slt_true_r4", dut.REGISTERS.registers[4], 32'd1);
    check("sub_r5", dut.REGISTERS.registers[5], 32'd10);
    check("and_r6", dut.REGISTERS.registers[6], 32'd5);
    check("or_r7", dut.REGISTERS.registers[7], 32'hFFFF_FFFF);
    check("slt_false_r8", dut.REGISTERS.registers[8], 32'd0);
    check("t2_queue_drained", exp_q.size(), 0);

    // lw $1,0x80; sw $1,0x40; lw $5,0x40
    new_test();
    put(0, 32'h8C01_0080);
    put(4, 32'hAC01_0040);
    put(8, 32'h8C05_0040);
    put(128, 32'h1234_5678);
    exp_fetches(0, 1); exp_rd(32'h40); exp_rd(32'h41);
    exp_fetches(4, 1); exp_wr(32'h20, 16'h1234); exp_wr(32'h21, 16'h5678);
    exp_fetches(8, 1); exp_rd(32'h20); exp_rd(32'h21);
    do_reset();
    run(20);
    check("lw_r1", dut.REGISTERS.registers[1], 32'h1234_5678);
    check("sw_mem_hi", 32'(mem[32'h20]), 32'h1234);
    check("sw_mem_lo", 32'(mem[32'h21]), 32'h5678);
    check("sw_write_cycles", wr_count, 2);
    check("lw_r5", dut.REGISTERS.registers[5], 32'h1234_5678);
    check("t3_queue_drained", exp_q.size(), 0);

    // beq taken, j, beq not taken; poison at 4, 8 and 20
    new_test();
    put(0,  32'h1000_0002);
    put(4,  32'h2002_0009);
    put(8,  32'h2002_0009);
    put(12, 32'h2003_0001);
    put(16, 32'h0800_0008);
    put(20, 32'h2002_0009);
    put(32, 32'h2004_0002);
    put(36, 32'h1004_0005);
    put(40, 32'h2005_0003);
    exp_fetches(0, 1); exp_fetches(12, 2); exp_fetches(32, 3);
    do_reset();
    run(28);
    check("beq_skip_r2", dut.REGISTERS.registers[2], 32'h0);
    check("beq_target_r3", dut.REGISTERS.registers[3], 32'd1);
    check("j_target_r4", dut.REGISTERS.registers[4], 32'd2);
    check("beq_not_taken_r5", dut.REGISTERS.registers[5], 32'd3);
    check("t4_queue_drained", exp_q.size(), 0);

    // $0 write ignored, unknown opcode and funct are NOPs
    new_test();
    put(0,  32'h2000_0009);
    put(4,  32'hFC00_0000);
    put(8,  32'h2006_0006);
    put(12, 32'h0022_1821);
    put(16, 32'h2007_0007);
    exp_fetches(0, 5);
    do_reset();
    run(24);
    check("r0_stays_zero", dut.REGISTERS.registers[0], 32'h0);
    check("nop_op_then_r6", dut.REGISTERS.registers[6], 32'd6);
    check("nop_funct_r3", dut.REGISTERS.registers[3], 32'h0);
    check("nop_funct_then_r7", dut.REGISTERS.registers[7], 32'd7);
    check("t5_queue_drained", exp_q.size(), 0);

    // reset during MEM_LO of sw aborts the second halfword write
    new_test();
    put(0, 32'hAC00_0040);
    mem[32'h20] = 16'hAAAA;
    mem[32'h21] = 16'hBEEF;
    exp_fetches(0, 1); exp_wr(32'h20, 16'h0000);
    do_reset();
    run(5);
    reset = 1'b1;
    #1;
    check("abort_bus_idle", {29'b0, ce, oute, wre}, 32'h7);
    run(2);
    check("abort_write_count", wr_count, 1);
    check("abort_mem_hi", 32'(mem[32'h20]), 32'h0);
    check("abort_mem_lo", 32'(mem[32'h21]), 32'hBEEF);
    check("t6a_queue_drained", exp_q.size(), 0);
    exp_rd(0);
    reset = 1'b0;
    run(1);
    check("restart_fetch_seen", exp_q.size(), 0);
    check("restart_write_count", wr_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
